rib_arb: RTL

RIB_ARB -- requirements
Module: rib_arb

---
 rtl/tinyriscv_pkg.sv | 22 ++
 rtl/rr_pick.sv | 37 +++
 rtl/rib_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared arbiter definitions: FSM state encoding, default master count
// and the fixed master index assignments on the RIB bus.
package tinyriscv_pkg;

    localparam int NUM_MASTER_DEF = 4;

    localparam int M_CORE_EX  = 0;
    localparam int M_CORE_PC  = 1;
    localparam int M_JTAG     = 2;
    localparam int M_UART_DBG = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index width that stays legal (>=1) even for a single master.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first requester at or above i_ptr,
// wrapping to the lowest requester when nothing is found above it.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic [N-1:0] w_hi_req;
    logic [N-1:0] w_hi_gnt;
    logic [N-1:0] w_lo_gnt;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_hi
            assign w_hi_req[gi] = i_req[gi] & (IDX_W'(gi) >= i_ptr);
        end
    endgenerate

    // Lowest set bit isolation: x & -x.
    assign w_hi_gnt = w_hi_req & (~w_hi_req + N'(1));
    assign w_lo_gnt = i_req & (~i_req + N'(1));
    assign o_gnt    = (|w_hi_req) ? w_hi_gnt : w_lo_gnt;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (o_gnt[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rib_arb.sv
// RIB bus arbiter: debug masters take absolute priority, round-robin within
// the competing class, one grant at a time with ready/abort/timeout release.
module rib_arb
    import tinyriscv_pkg::*;
#(
    parameter int                    NUM_MASTER     = NUM_MASTER_DEF,
    parameter logic [NUM_MASTER-1:0] PRIO_MASK      = NUM_MASTER'(4'b1100),
    parameter int                    TIMEOUT_CYCLES = 256,
    localparam int                   IDX_W          = idx_width(NUM_MASTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_MASTER-1:0] req_i,
    input  logic                  ready_i,
    output logic [NUM_MASTER-1:0] gnt_o,
    output logic [IDX_W-1:0]      gnt_idx_o,
    output logic                  busy_o,
    output logic                  hold_flag_o,
    output logic                  timeout_o
);

    // Masters other than the two core ports stall the pipeline while granted.
    localparam logic [NUM_MASTER-1:0] NON_CORE_MASK = ~NUM_MASTER'(3);

    arb_state_t            r_state;
    logic [NUM_MASTER-1:0] r_gnt;
    logic [IDX_W-1:0]      r_gnt_idx;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [15:0]           r_wait_cnt;
    logic                  r_timeout;

    logic [NUM_MASTER-1:0] w_prio_req;
    logic                  w_prio_any;
    logic [NUM_MASTER-1:0] w_prio_gnt;
    logic [IDX_W-1:0]      w_prio_idx;
    logic [NUM_MASTER-1:0] w_all_gnt;
    logic [IDX_W-1:0]      w_all_idx;
    logic [NUM_MASTER-1:0] w_win_gnt;
    logic [IDX_W-1:0]      w_win_idx;
    logic [IDX_W-1:0]      w_next_ptr;
    logic                  w_req_drop;
    logic                  w_wait_last;

    assign w_prio_req = req_i & PRIO_MASK;
    assign w_prio_any = |w_prio_req;

    rr_pick #(
        .N     (NUM_MASTER),
        .IDX_W (IDX_W)
    ) u_pick_prio (
        .i_req (w_prio_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_prio_gnt),
        .o_idx (w_prio_idx)
    );

    rr_pick #(
        .N     (NUM_MASTER),
        .IDX_W (IDX_W)
    ) u_pick_all (
        .i_req (req_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_all_gnt),
        .o_idx (w_all_idx)
    );

    assign w_win_gnt   = w_prio_any ? w_prio_gnt : w_all_gnt;
    assign w_win_idx   = w_prio_any ? w_prio_idx : w_all_idx;
    assign w_next_ptr  = (r_gnt_idx == IDX_W'(NUM_MASTER - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
    assign w_req_drop  = ~|(req_i & r_gnt);
    assign w_wait_last = (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Release priority: ready completion beats abort, abort beats timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_state    <= ST_BUSY;
                        r_gnt      <= w_win_gnt;
                        r_gnt_idx  <= w_win_idx;
                        r_wait_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (ready_i) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_gnt_idx <= '0;
                        r_rr_ptr  <= w_next_ptr;
                    end else if (w_req_drop) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_gnt_idx <= '0;
                    end else if (w_wait_last) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_gnt_idx <= '0;
                        r_rr_ptr  <= w_next_ptr;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_idx_o   = r_gnt_idx;
    assign busy_o      = (r_state == ST_BUSY);
    assign timeout_o   = r_timeout;
    assign hold_flag_o = (req_i[M_CORE_EX] & ~r_gnt[M_CORE_EX]) | (|(r_gnt & NON_CORE_MASK));

endmodule
